dmem_responder: RTL and testbench

Memory-side target for the core's data-memory port: accepts load/store requests over a valid/ready handshake, applies a fixed programmable access latency, performs byte-lane writes or full-word reads on an internal word array, and returns one response per request over a second valid/ready handshake. It sits between the core's load/store path and the data storage. It replaces the zero-latency combinational memory with a back-pressurable responder.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_array.sv | 49 ++++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_e  responder FSM states (IDLE, WAIT, RESP)
//   dmem_req_t    latched load/store request payload
//   DMEM_LEGAL_BE byte-enable patterns accepted for stores when the
//                 DMEM_ALIGN_CHECK_EN build option is enabled
package dmem_pkg;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned DMEM_ADDR_W = 32;
   localparam int unsigned DMEM_BE_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [DMEM_BE_W-1:0]   be;
   } dmem_req_t;

   // Naturally aligned byte, halfword and word lanes; 0000 is a legal no-op store.
   localparam int unsigned DMEM_N_LEGAL_BE = 8;
   localparam logic [DMEM_N_LEGAL_BE*DMEM_BE_W-1:0] DMEM_LEGAL_BE = {
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111
   };

   function automatic logic dmem_be_legal(input logic [DMEM_BE_W-1:0] be);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < DMEM_N_LEGAL_BE; i++) begin
         hit = hit | (be == DMEM_LEGAL_BE[i*DMEM_BE_W +: DMEM_BE_W]);
      end
      return hit;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the core's
// load/store path (master) and the memory responder (slave).
//   req_valid/req_ready  request handshake; req_we, req_addr, req_wdata, req_be payload
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_err payload
interface dmem_responder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   import dmem_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DMEM_BE_W-1:0]  req_be;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: synchronous word array with per-byte write enables and a
// registered read port.
//   clk, rst_n  clock and async active-low reset (read register only)
//   i_acc       access strobe; updates the read register
//   i_rd        1 = load the addressed word, 0 = clear the read register
//   i_idx       word index
//   i_wdata     write data, lane-aligned
//   i_be        per-lane write enables (caller gates with the access)
//   o_rdata     registered read data
module dmem_array #(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS),
   localparam int unsigned BE_W        = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_acc,
   input  logic                  i_rd,
   input  logic [IDX_W-1:0]      i_idx,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [BE_W-1:0]       i_be,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (i_be[i]) begin
            r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   // Non-load accesses clear the read register so store/error responses carry 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_acc) begin
         r_rdata <= i_rd ? r_mem[i_idx] : '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target with a fixed access latency of
// WAIT_CYCLES extra cycles and back-pressurable responses.
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    dmem_responder_if.slave (request and response handshakes)
// Build option: DMEM_ALIGN_CHECK_EN flags misaligned addresses and illegal
// store byte-enables with rsp_err and suppresses their array write; without
// it rsp_err is constant 0 and req_addr[1:0] is ignored.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_WAIT = ST_WAIT;
   localparam logic [1:0] S_RESP = ST_RESP;

   logic [1:0]            r_state;
   logic [1:0]            w_nxt_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_nxt_cnt;
   dmem_req_t             r_req;
   dmem_req_t             w_in_req;
   dmem_req_t             w_acc_req;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic                  w_req_ready;
   logic                  w_accept;
   logic                  w_latch;
   logic                  w_acc;
   logic                  w_err;
   logic [DMEM_BE_W-1:0]  w_wr_be;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_unused_addr;

   // Incoming request payload
   always_comb begin
      w_in_req       = '0;
      w_in_req.we    = bus.req_we;
      w_in_req.addr  = DMEM_ADDR_W'(bus.req_addr[ADDR_WIDTH-1:0]);
      w_in_req.wdata = DMEM_DATA_W'(bus.req_wdata[DATA_WIDTH-1:0]);
      w_in_req.be    = bus.req_be;
   end

   assign w_req_ready = reset && ((r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready));
   assign w_accept    = bus.req_valid && w_req_ready;

   // Zero-wait accesses use the request on the bus; otherwise the latched copy.
   assign w_acc_req = (r_state == S_WAIT) ? r_req : w_in_req;

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_err = (w_acc_req.addr[1:0] != 2'b00) || (w_acc_req.we && !dmem_be_legal(w_acc_req.be));
`else
   assign w_err = 1'b0;
`endif

   // Next-state and access control
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_latch     = 1'b0;
      w_acc       = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_acc       = 1'b1;
               w_nxt_state = S_RESP;
            end else begin
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_nxt_state = S_IDLE;
            end
         end
         default: ;
      endcase
      // Accept from IDLE, or from RESP in the same cycle the response retires.
      if (w_accept) begin
         w_latch = 1'b1;
         if (WAIT_CYCLES == 0) begin
            w_acc       = 1'b1;
            w_nxt_state = S_RESP;
         end else begin
            w_nxt_state = S_WAIT;
            w_nxt_cnt   = CNT_W'(WAIT_CYCLES) - CNT_W'(1);
         end
      end
   end

   // State, latched request and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_req       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         r_rsp_valid <= (w_nxt_state == S_RESP);
         if (w_latch) begin
            r_req <= w_in_req;
         end
         if (w_acc) begin
            r_rsp_err <= w_err;
         end
      end
   end

   assign w_wr_be = (w_acc && w_acc_req.we && !w_err) ? w_acc_req.be : '0;

   dmem_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .rst_n   (reset),
      .i_acc   (w_acc),
      .i_rd    (!w_acc_req.we && !w_err),
      .i_idx   (w_acc_req.addr[IDX_W+1:2]),
      .i_wdata (DATA_WIDTH'(w_acc_req.wdata)),
      .i_be    (w_wr_be),
      .o_rdata (w_rdata)
   );

   // Address bits outside the word index do not select storage.
   assign w_unused_addr = ^{w_acc_req.addr[DMEM_ADDR_W-1:IDX_W+2], w_acc_req.addr[1:0]};

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = w_rdata;
   assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (WAIT_CYCLES=2 on port 0, 0 on port 1)
// driven by directed vectors and compared each cycle against a
// transaction-level model (word memory + one outstanding expected response).
`timescale 1ns/1ps
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        d_req_valid [2];
   logic        d_req_we    [2];
   logic [31:0] d_req_addr  [2];
   logic [31:0] d_req_wdata [2];
   logic [3:0]  d_req_be    [2];
   logic        d_rsp_ready [2];
   logic        s_req_ready [2];
   logic        s_rsp_valid [2];
   logic        s_rsp_err   [2];
   logic [31:0] s_rsp_rdata [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
      assign bus.req_valid   = d_req_valid[g];
      assign bus.req_we      = d_req_we[g];
      assign bus.req_addr    = d_req_addr[g];
      assign bus.req_wdata   = d_req_wdata[g];
      assign bus.req_be      = d_req_be[g];
      assign bus.rsp_ready   = d_rsp_ready[g];
      assign s_req_ready[g]  = bus.req_ready;
      assign s_rsp_valid[g]  = bus.rsp_valid;
      assign s_rsp_err[g]    = bus.rsp_err;
      assign s_rsp_rdata[g]  = bus.rsp_rdata;
      dmem_responder #(
         .DATA_WIDTH  (32),
         .ADDR_WIDTH  (32),
         .DEPTH_WORDS (1024),
         .WAIT_CYCLES ((g == 0) ? 32'd2 : 32'd0)
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      bit          known;
      logic [31:0] rdata;
      logic        err;
      int          due;
      bit          we;
      int          idx;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t        slot    [2];
   bit          pend    [2];
   logic [31:0] mdl_mem [2][1024];
   bit          mdl_vld [2][1024];
   int          hs_cnt  [2];
   int          hs_last [2];

   function automatic int wait_of(input int p);
      return (p == 0) ? 2 : 0;
   endfunction

   function automatic logic model_err(input bit we, input logic [31:0] a, input logic [3:0] be);
`ifdef DMEM_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00) ||
             (we && !(be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111}));
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_port(input int p);
      exp_t e;
      bit   due_now;
      if (!reset) begin
         chk($sformatf("p%0d_reset_rsp_valid", p), 32'(s_rsp_valid[p]), 32'd0);
         chk($sformatf("p%0d_reset_req_ready", p), 32'(s_req_ready[p]), 32'd0);
         chk($sformatf("p%0d_reset_rsp_rdata", p), s_rsp_rdata[p], 32'd0);
         chk($sformatf("p%0d_reset_rsp_err", p), 32'(s_rsp_err[p]), 32'd0);
         pend[p] = 1'b0;
      end else begin
         due_now = pend[p] && (cyc >= slot[p].due);
         chk($sformatf("p%0d_rsp_valid", p), 32'(s_rsp_valid[p]), 32'(due_now));
         chk($sformatf("p%0d_req_ready", p), 32'(s_req_ready[p]),
             32'(!pend[p] || (due_now && d_rsp_ready[p])));
         if (due_now) begin
            if (slot[p].known) chk($sformatf("p%0d_rsp_rdata", p), s_rsp_rdata[p], slot[p].rdata);
            chk($sformatf("p%0d_rsp_err", p), 32'(s_rsp_err[p]), 32'(slot[p].err));
            if (d_rsp_ready[p]) begin
               if (slot[p].we && !slot[p].err) begin
                  for (int l = 0; l < 4; l++) begin
                     if (slot[p].be[l]) mdl_mem[p][slot[p].idx][8*l +: 8] = slot[p].wdata[8*l +: 8];
                  end
                  mdl_vld[p][slot[p].idx] = 1'b1;
               end
               pend[p]    = 1'b0;
               hs_cnt[p]  = hs_cnt[p] + 1;
               hs_last[p] = cyc;
            end
         end
         if (d_req_valid[p] && !pend[p]) begin
            e.we    = d_req_we[p];
            e.idx   = int'((d_req_addr[p] >> 2) % 32'd1024);
            e.wdata = d_req_wdata[p];
            e.be    = d_req_be[p];
            e.due   = cyc + wait_of(p) + 1;
            e.err   = model_err(d_req_we[p], d_req_addr[p], d_req_be[p]);
            if (e.we || e.err) begin
               e.known = 1'b1;
               e.rdata = 32'd0;
            end else begin
               e.known = mdl_vld[p][e.idx];
               e.rdata = mdl_mem[p][e.idx];
            end
            slot[p] = e;
            pend[p] = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) check_port(p);
   end

   // ---------------- directed stimulus ----------------
   task automatic xact(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
      int t0;
      int n;
      @(posedge clk); #1;
      d_req_valid[p] = 1'b1;
      d_req_we[p]    = we;
      d_req_addr[p]  = a;
      d_req_wdata[p] = wd;
      d_req_be[p]    = be;
      d_rsp_ready[p] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_req_ready[p] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("xact_accept", 32'(s_req_ready[p]), 32'd1);
      t0 = cyc;
      @(posedge clk); #1;
      d_req_valid[p] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_rsp_valid[p] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("xact_response", 32'(s_rsp_valid[p]), 32'd1);
      rd  = s_rsp_rdata[p];
      er  = s_rsp_err[p];
      lat = cyc - t0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          n;
      int          t0;
      int          hs0;
      int          first;

      for (int p = 0; p < 2; p++) begin
         d_req_valid[p] = 1'b0;
         d_req_we[p]    = 1'b0;
         d_req_addr[p]  = 32'd0;
         d_req_wdata[p] = 32'd0;
         d_req_be[p]    = 4'd0;
         d_rsp_ready[p] = 1'b1;
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Store then load
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
      chk("store_rdata", rd, 32'd0);
      chk("store_latency", 32'(lat), 32'd3);
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      chk("load_rdata", rd, 32'hDEADBEEF);
      chk("load_latency", 32'(lat), 32'd3);

      // Byte lanes
      xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      xact(0, 1'b0, 32'h10, 32'h0, 4'b1010, rd, er, lat);
      chk("lane0_rdata", rd, 32'hDEADBEAA);
      xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
      chk("be0_store_rdata", rd, 32'd0);
      xact(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      chk("be0_unchanged", rd, 32'hDEADBEAA);

      // Back-pressure, then accept in the release cycle
      @(posedge clk); #1;
      d_rsp_ready[0] = 1'b0;
      d_req_valid[0] = 1'b1;
      d_req_we[0]    = 1'b0;
      d_req_addr[0]  = 32'h10;
      @(negedge clk);
      chk("bp_accept", 32'(s_req_ready[0]), 32'd1);
      @(posedge clk); #1;
      d_req_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", 32'(s_rsp_valid[0]), 32'd1);
         chk("bp_rsp_rdata", s_rsp_rdata[0], 32'hDEADBEAA);
         chk("bp_req_ready", 32'(s_req_ready[0]), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      d_rsp_ready[0] = 1'b1;
      d_req_valid[0] = 1'b1;
      d_req_we[0]    = 1'b1;
      d_req_addr[0]  = 32'h14;
      d_req_wdata[0] = 32'h0BADF00D;
      d_req_be[0]    = 4'b1111;
      @(negedge clk);
      chk("bp_release_accept", 32'(s_req_ready[0]), 32'd1);
      t0 = cyc;
      @(posedge clk); #1;
      d_req_valid[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_release_latency", 32'(cyc - t0), 32'd3);
      xact(0, 1'b0, 32'h14, 32'h0, 4'b0000, rd, er, lat);
      chk("bp_store_readback", rd, 32'h0BADF00D);

      // Address wrap-around
      xact(0, 1'b1, 32'h1000, 32'h12345678, 4'b1111, rd, er, lat);
      xact(0, 1'b0, 32'h0000, 32'h0, 4'b0000, rd, er, lat);
      chk("wrap_rdata", rd, 32'h12345678);

      // Reset during a store's wait drops the write
      xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd, er, lat);
      @(posedge clk); #1;
      d_req_valid[0] = 1'b1;
      d_req_we[0]    = 1'b1;
      d_req_addr[0]  = 32'h20;
      d_req_wdata[0] = 32'hBAD0BAD0;
      d_req_be[0]    = 4'b1111;
      @(negedge clk);
      chk("rst_store_accept", 32'(s_req_ready[0]), 32'd1);
      @(posedge clk); #1;
      d_req_valid[0] = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_rsp_valid", 32'(s_rsp_valid[0]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
      chk("rst_old_value", rd, 32'hCAFEF00D);

`ifdef DMEM_ALIGN_CHECK_EN
      xact(0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'b0110, rd, er, lat);
      chk("err_store_err", 32'(er), 32'd1);
      chk("err_store_rdata", rd, 32'd0);
      chk("err_store_latency", 32'(lat), 32'd3);
      xact(0, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
      chk("err_no_write", rd, 32'hCAFEF00D);
      chk("err_clean_load", 32'(er), 32'd0);
`endif

      // WAIT_CYCLES=0 streaming: 4 stores then 4 loads back-to-back
      hs0 = hs_cnt[1];
      first = 0;
      @(posedge clk); #1;
      d_rsp_ready[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d_req_valid[1] = 1'b1;
         d_req_we[1]    = (i < 4);
         d_req_addr[1]  = (i < 4) ? 32'(i * 4) : 32'((i - 4) * 4);
         d_req_wdata[1] = 32'hA5A50000 + 32'(i);
         d_req_be[1]    = 4'b1111;
         @(negedge clk);
         chk("stream_ready", 32'(s_req_ready[1]), 32'd1);
         if (i == 0) first = cyc;
         @(posedge clk); #1;
      end
      d_req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("stream_count", 32'(hs_cnt[1] - hs0), 32'd8);
      chk("stream_last_cycle", 32'(hs_last[1] - first), 32'd8);
      xact(1, 1'b0, 32'hC, 32'h0, 4'b0000, rd, er, lat);
      chk("stream_readback", rd, 32'hA5A50003);
      chk("stream_latency", 32'(lat), 32'd1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
